// File: rtl/find_first_pkg.sv
`default_nettype none
// ============================================================================
// Module      : find_first_pkg
// Description : Shared constants and state encoding for the iterative
//               find-first scanner and its combinational helper.
// Revision    : 1.0 - initial release
// ============================================================================
package find_first_pkg;

  // Scan-order selector values for in_msb_first / msb_first.
  localparam logic SCAN_LSB_FIRST = 1'b0;
  localparam logic SCAN_MSB_FIRST = 1'b1;

  // Transaction state: IDLE waits for a mask, BUSY emits beats.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage : find_first_pkg
`default_nettype wire

// File: rtl/find_first_dir.sv
`default_nettype none
// ============================================================================
// Module      : find_first_dir
// Description : Combinational find-first-set with selectable scan order.
//               Returns the absolute index (0 = LSB) of the first set bit
//               encountered when scanning in the requested direction.
// Ports       : data_i    - vector to scan
//               msb_first - 1: highest set index, 0: lowest set index
//               data_o    - absolute index of the first set bit (0 if none)
//               found_o   - at least one bit of data_i is set
// Revision    : 1.0 - initial release
// ============================================================================
module find_first_dir
  import find_first_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 5
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  msb_first,
  output logic [DATA_DEPTH-1:0] data_o,
  output logic                  found_o
);

  // The loop walks away from the preferred end so the last assignment made
  // is the preferred match: ascending for MSB-first, descending for LSB-first.
  always_comb begin
    data_o  = '0;
    found_o = 1'b0;
    if (msb_first == SCAN_MSB_FIRST) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (data_i[i]) begin
          data_o  = DATA_DEPTH'(i);
          found_o = 1'b1;
        end
      end
    end else begin
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
        if (data_i[i]) begin
          data_o  = DATA_DEPTH'(i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule : find_first_dir
`default_nettype wire

// File: rtl/find_first_iter.sv
`default_nettype none
// ============================================================================
// Module      : find_first_iter
// Description : Iterative find-first. Accepts one mask per transaction and
//               emits, one beat per cycle, the index of every bit equal to
//               the requested target, in the requested scan order. Valid/
//               ready handshakes on both sides; back-to-back transactions
//               with no bubble.
// Ports       : clk, rst (async, active-high), flush (sync abort)
//               in_valid/in_ready/in_data/in_target/in_msb_first - mask input
//               out_valid/out_ready/out_idx/out_last/out_empty   - beat output
// Revision    : 1.0 - initial release
// ============================================================================
module find_first_iter
  import find_first_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_target,
  input  logic                  in_msb_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_DEPTH-1:0] out_idx,
  output logic                  out_last,
  output logic                  out_empty
);

  localparam logic [DATA_WIDTH-1:0] c_one = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_pend,  w_pend_nxt;
  logic                    r_dir,   w_dir_nxt;
  logic                    r_empty, w_empty_nxt;

  logic                    w_busy;
  logic [DATA_WIDTH-1:0]   w_match;
  logic [DATA_DEPTH-1:0]   w_first_idx;
  logic                    w_found;
  logic                    w_one_left;
  logic                    w_in_fire;
  logic                    w_out_fire;

  find_first_dir #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_find_first_dir (
    .data_i    (r_pend),
    .msb_first (r_dir),
    .data_o    (w_first_idx),
    .found_o   (w_found)
  );

  assign w_busy     = (r_state == BUSY);
  assign w_match    = in_target ? in_data : ~in_data;
  // Exactly one pending bit means the current beat is the final one.
  assign w_one_left = (r_pend != '0) && ((r_pend & (r_pend - c_one)) == '0);

  // Outputs are driven from registers only and forced to zero in IDLE.
  assign out_valid  = w_busy;
  assign out_idx    = (w_busy && w_found) ? w_first_idx : '0;
  assign out_last   = w_busy && (r_empty || w_one_left);
  assign out_empty  = w_busy && r_empty;

  assign w_out_fire = out_valid && out_ready;
  // Accepting during the final beat gives back-to-back transactions; flush
  // blocks acceptance for its cycle.
  assign in_ready   = !flush && (!w_busy || (w_out_fire && out_last));
  assign w_in_fire  = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_dir_nxt   = r_dir;
    w_empty_nxt = r_empty;
    if (flush) begin
      w_state_nxt = IDLE;
      w_pend_nxt  = '0;
      w_empty_nxt = 1'b0;
    end else if (w_in_fire) begin
      // in_fire only happens in IDLE or on the final beat, so the previous
      // transaction's residue can be overwritten outright.
      w_state_nxt = BUSY;
      w_pend_nxt  = w_match;
      w_dir_nxt   = in_msb_first;
      w_empty_nxt = (w_match == '0);
    end else if (w_out_fire) begin
      w_pend_nxt = r_pend & ~(c_one << out_idx);
      if (out_last) begin
        w_state_nxt = IDLE;
        w_empty_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_dir   <= SCAN_LSB_FIRST;
      r_empty <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_dir   <= w_dir_nxt;
      r_empty <= w_empty_nxt;
    end
  end

endmodule : find_first_iter
`default_nettype wire

// File: tb/tb_find_first_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_find_first_iter
// Description : Self-checking bench for find_first_iter. Expected beats come
//               from a list-based model built directly from the mask, target
//               and scan order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_find_first_iter;

  localparam int DW = 32;
  localparam int DD = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_target;
  logic          in_msb_first;
  logic          out_valid;
  logic          out_ready;
  logic [DD-1:0] out_idx;
  logic          out_last;
  logic          out_empty;

  int checks   = 0;
  int failures = 0;

  int exp_q[$];
  logic exp_empty;

  always #5 clk = ~clk;

  find_first_iter #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_target    (in_target),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .out_empty    (out_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list every matching bit position in the requested order.
  function automatic void build_expected(input logic [DW-1:0] d, input logic t, input logic m);
    logic [DW-1:0] mv;
    mv = t ? d : ~d;
    exp_q.delete();
    exp_empty = (mv == '0);
    if (exp_empty) exp_q.push_back(0);
    else
      for (int k = 0; k < DW; k++) begin
        int b;
        b = m ? (DW - 1 - k) : k;
        if (mv[b]) exp_q.push_back(b);
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a mask and wait (bounded) for acceptance; returns one cycle after
  // the accepting edge, when the first beat is visible.
  task automatic send(input logic [DW-1:0] d, input logic t, input logic m);
    int n;
    n = 0;
    build_expected(d, t, m);
    in_data = d; in_target = t; in_msb_first = m; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data = $urandom;
    in_target = $urandom_range(0, 1);
    in_msb_first = $urandom_range(0, 1);
  endtask

  task automatic drain(input bit rand_ready);
    int cyc;
    int e;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("out_valid", out_valid, 1);
      chk("out_idx", out_idx, exp_q[0]);
      chk("out_last", out_last, exp_q.size() == 1);
      chk("out_empty", out_empty, exp_empty);
      if (out_ready) begin
        e = exp_q.pop_front();
        if (exp_q.size() == 0) chk("in_ready_on_last", in_ready, 1);
      end
      tick();
      cyc++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    out_ready = 1'b1;
    #1;
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_target = 1'b0; in_msb_first = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_empty", out_empty, 0);
    rst = 1'b0;
    tick();

    // Ones, MSB-first.
    send(32'h0000_8421, 1'b1, 1'b1);
    drain(1'b0);
    // Zeros, LSB-first.
    send(32'hFFFF_FFF5, 1'b0, 1'b0);
    drain(1'b0);
    // Empty mask.
    send(32'h0000_0000, 1'b1, 1'b1);
    drain(1'b0);

    // Backpressure then back-to-back.
    send(32'h8000_0001, 1'b1, 1'b1);
    out_ready = 1'b1; #1;
    chk("bp_idx31", out_idx, 31);
    chk("bp_last0", out_last, 0);
    tick();
    out_ready = 1'b0; #1;
    chk("bp_stall1_idx", out_idx, 0);
    chk("bp_stall1_last", out_last, 1);
    tick();
    chk("bp_stall2_valid", out_valid, 1);
    chk("bp_stall2_idx", out_idx, 0);
    chk("bp_stall2_last", out_last, 1);
    out_ready = 1'b1;
    in_data = 32'h0000_0002; in_target = 1'b1; in_msb_first = 1'b1; in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_last_idx", out_idx, 0);
    tick();
    in_valid = 1'b0; #1;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_idx", out_idx, 1);
    chk("b2b_last", out_last, 1);
    chk("b2b_empty", out_empty, 0);
    tick();
    chk("b2b_idle", out_valid, 0);

    // Flush during beat 2.
    send(32'hFFFF_FFFF, 1'b1, 1'b0);
    out_ready = 1'b1; #1;
    chk("fl_beat1", out_idx, 0);
    tick();
    chk("fl_beat2", out_idx, 1);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h0000_00F0; #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready_after", in_ready, 1);
    chk("fl_out_idx", out_idx, 0);
    tick(); tick();
    chk("fl_still_idle", out_valid, 0);

    // Asynchronous reset mid-transaction.
    send(32'hFFFF_FFFF, 1'b1, 1'b0);
    tick(); tick();
    chk("rs_pre_valid", out_valid, 1);
    rst = 1'b1; #1;
    chk("rs_out_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_out_idx", out_idx, 0);
    chk("rs_out_last", out_last, 0);
    chk("rs_out_empty", out_empty, 0);
    #1 rst = 1'b0;
    tick(); tick();
    chk("rs_still_idle", out_valid, 0);

    // Full scan, MSB-first.
    send(32'hFFFF_FFFF, 1'b1, 1'b1);
    drain(1'b0);
    // Full scan of zeros, LSB-first, with random stalls.
    send(32'h0000_0000, 1'b0, 1'b0);
    drain(1'b1);

    // Random transactions, mixed densities and stalls.
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = $urandom & $urandom & $urandom;
        2: d = $urandom | $urandom | $urandom;
        default: d = 32'h1 << $urandom_range(0, 31);
      endcase
      send(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_find_first_iter
`default_nettype wire

// File: doc/find_first_iter.md
Name: find_first_iter

Overview:
- Sequential successor to the combinational find-first: accepts one DATA_WIDTH mask per transaction and emits, one per cycle, the bit index of every bit equal to `target`.
- Scan order (MSB->LSB or LSB->MSB) is selectable per transaction.
- Used in the SIMT/LSU path to walk active-thread or pending-request masks with valid/ready backpressure on both sides.

Parameters:
- DATA_WIDTH, 32, mask width; must be >= 2.
- DATA_DEPTH, 5, index width; must equal $clog2(DATA_WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; drops the current transaction.
- in_valid  input  1  new mask offered.
- in_ready  output  1  block can accept a mask this cycle.
- in_data  input  DATA_WIDTH  mask to scan.
- in_target  input  1  1: report ones; 0: report zeros.
- in_msb_first  input  1  1: scan MSB->LSB; 0: scan LSB->MSB.
- out_valid  output  1  out_idx/out_last/out_empty are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  DATA_DEPTH  absolute bit position (0 = LSB) of the current match.
- out_last  output  1  current beat is the final beat of the transaction.
- out_empty  output  1  mask had no matching bit; single beat, out_idx = 0.

Behaviour:
- State registers: state {IDLE, BUSY}, pend[DATA_WIDTH-1:0], dir, empty.
- Reset values: state = IDLE, pend = 0, dir = 0, empty = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, out_empty = 0.
- Accept condition: in_fire = in_valid && in_ready.
  - in_ready = (state == IDLE) || (out_valid && out_ready && out_last).
  - A new mask may therefore be accepted in the same cycle the last beat leaves, giving back-to-back transactions with no bubble.
- On in_fire, registered on the next edge:
  - pend <= in_target ? in_data : ~in_data
  - dir <= in_msb_first
  - empty <= (match vector == 0)
  - state <= BUSY
- Latency: first beat is valid the cycle after in_fire. One beat per cycle thereafter while out_ready = 1.
- BUSY outputs, combinational from registers only:
  - out_valid = 1.
  - out_idx = first set bit of pend in scan order dir. MSB-first gives the highest set index; LSB-first gives the lowest.
  - out_last = empty || (pend has exactly one bit set).
  - out_empty = empty.
- Outputs in IDLE: out_valid = 0. out_idx, out_last and out_empty are all forced to 0.
- On out fire (out_valid && out_ready):
  - pend bit out_idx <= 0.
  - If out_last, then state <= IDLE and empty <= 0, unless in_fire occurs in the same cycle. In that case the new transaction is loaded and state stays BUSY.
- Backpressure: while out_valid && !out_ready, out_idx, out_last and out_empty hold stable, and pend is unchanged.
- Full mask with target matching every bit: DATA_WIDTH beats, strictly ordered, no skips or repeats.
- Single matching bit: exactly one beat, with out_last = 1.
- flush:
  - Has priority over every other event.
  - Next edge: state = IDLE, pend = 0, empty = 0.
  - in_ready is forced to 0 during the flush cycle; no mask is accepted.
- Asynchronous rst mid-transaction returns all state to the reset values immediately. No beat is produced for the interrupted mask.
- in_data, in_target and in_msb_first are sampled only on in_fire.

Decomposition:
- Shared package find_first_pkg holds:
  - SCAN_LSB_FIRST = 1'b0 and SCAN_MSB_FIRST = 1'b1 constants.
  - The state typedef/localparams IDLE = 1'b0 and BUSY = 1'b1.
- One combinational sub-module: find_first_dir (DATA_WIDTH, DATA_DEPTH).
  - Inputs: data_i, msb_first. Outputs: data_o (absolute bit index of the first set bit) and found_o.
  - Instantiated once on pend.
- Exactly-one-bit detection (pend != 0 && (pend & (pend-1)) == 0) is done inline.

Test Plan:
- Basic ones, MSB-first: in_data = 32'h0000_8421, target = 1, msb_first = 1, out_ready = 1 -> beats idx 15, 10, 5, 0 on consecutive cycles, out_last only on idx 0; in_ready = 1 again during the idx 0 beat.
- Zeros, LSB-first: in_data = 32'hFFFF_FFF5, target = 0, msb_first = 0 -> beats idx 1, 3, with out_last on idx 3.
- Empty mask: in_data = 0, target = 1 -> one beat with out_empty = 1, out_last = 1, out_idx = 0; then IDLE.
- Backpressure and back-to-back:
  - Mask 32'h8000_0001 MSB-first, out_ready toggling 1,0,0,1 -> idx 31 accepted, idx 0 held stable for 2 stalled cycles.
  - Second mask 32'h0000_0002 presented during the last beat -> accepted in that cycle, beat idx 1 follows the next cycle with no gap.
- Flush and reset:
  - flush asserted during beat 2 of 32'hFFFF_FFFF (LSB-first) -> next cycle out_valid = 0, in_ready = 1, no further beats.
  - Repeat with rst pulsed mid-transaction -> out_valid = 0 immediately, all outputs at reset values.
- Full scan: in_data = 32'hFFFF_FFFF, target = 1, msb_first = 1 -> 32 beats, idx 31 down to 0, each index exactly once, out_last only on beat 32.
